// File: rtl/disp_arbiter_if.sv
// Display-path bundle between the value sources and the display arbiter.
// Sources drive req/urgent/req_num; the arbiter returns grant, shown value and blanking.
interface disp_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      urgent;
  logic [16*NREQ-1:0]   req_num;
  logic [NREQ-1:0]      gnt;
  logic [15:0]          number;
  logic                 blank;

  modport master (
    output req, urgent, req_num,
    input  gnt, number, blank
  );

  modport slave (
    input  req, urgent, req_num,
    output gnt, number, blank
  );
endinterface

// File: rtl/disp_arbiter.sv
// Shares the 4-digit display between NREQ sources: round-robin rotation of normal
// requesters, preempted by urgent requesters that hold the display and flash it.
module disp_arbiter #(
  parameter int NREQ        = 4,
  parameter int DWELL_MS    = 2000,
  parameter int MIN_HOLD_MS = 500,
  parameter int BLINK_MS    = 250
) (
  input  logic           ms_clock,
  input  logic           reset,
  disp_arbiter_if.slave  arb
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(DWELL_MS) + 1;
  localparam int HW = $clog2(MIN_HOLD_MS) + 1;
  localparam int BW = $clog2(BLINK_MS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_URGENT} state_t;

  state_t          r_state,     w_state_next;
  logic [IW-1:0]   r_owner,     w_owner_next;
  logic [IW-1:0]   r_rr_last,   w_rr_last_next;
  logic [NREQ-1:0] r_gnt,       w_gnt_next;
  logic [15:0]     r_number,    w_number_next;
  logic            r_blank,     w_blank_next;
  logic [DW-1:0]   r_dwell_cnt, w_dwell_next;
  logic [HW-1:0]   r_hold_cnt,  w_hold_next;
  logic [BW-1:0]   r_blink_cnt, w_blink_next;

  logic [15:0]     w_num [NREQ];
  logic [NREQ-1:0] w_urg_vec;
  logic            w_urg_any,  w_pick_any;
  logic [IW-1:0]   w_urg_idx,  w_pick_idx, w_rr_base;
  logic            w_go_urgent, w_go_rotate, w_go_idle;
  logic            w_dwell_exp, w_hold_done;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_num
    assign w_num[gi] = arb.req_num[16*gi +: 16];
  end

  assign w_urg_vec   = arb.urgent & arb.req;
  assign w_dwell_exp = (r_dwell_cnt >= DW'(DWELL_MS - 1));
  assign w_hold_done = (r_hold_cnt >= HW'(MIN_HOLD_MS - 1));
  // In ROTATE the current owner is the rotation base; it becomes rr_last on handover.
  assign w_rr_base   = (r_state == S_ROTATE) ? r_owner : r_rr_last;

  always_comb begin
    w_urg_any = 1'b0;
    w_urg_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_urg_vec[i]) begin
        w_urg_any = 1'b1;
        w_urg_idx = IW'(i);
      end
    end
  end

  // Circular search from base+1: lowest requester above base, else lowest overall.
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (arb.req[i]) begin
        w_pick_any = 1'b1;
        w_pick_idx = IW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (arb.req[i] && (i > int'(w_rr_base))) begin
        w_pick_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_rr_last_next = r_rr_last;
    w_gnt_next     = r_gnt;
    w_number_next  = r_number;
    w_blank_next   = r_blank;
    w_dwell_next   = r_dwell_cnt;
    w_hold_next    = r_hold_cnt;
    w_blink_next   = r_blink_cnt;
    w_go_urgent    = 1'b0;
    w_go_rotate    = 1'b0;
    w_go_idle      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_urg_any)       w_go_urgent = 1'b1;
        else if (w_pick_any) w_go_rotate = 1'b1;
      end
      S_ROTATE: begin
        if (w_urg_any) begin
          w_go_urgent    = 1'b1;
          w_rr_last_next = r_owner;
        end else if (w_dwell_exp || !arb.req[r_owner]) begin
          w_rr_last_next = r_owner;
          if (w_pick_any) w_go_rotate = 1'b1;
          else            w_go_idle   = 1'b1;
        end else begin
          w_dwell_next  = (r_dwell_cnt >= DW'(DWELL_MS)) ? r_dwell_cnt : r_dwell_cnt + 1'b1;
          w_number_next = w_num[r_owner];
        end
      end
      S_URGENT: begin
        w_hold_next = (r_hold_cnt >= HW'(MIN_HOLD_MS)) ? r_hold_cnt : r_hold_cnt + 1'b1;
        if (r_blink_cnt >= BW'(BLINK_MS - 1)) begin
          w_blink_next = '0;
          w_blank_next = ~r_blank;
        end else begin
          w_blink_next = r_blink_cnt + 1'b1;
        end
        // Once the owner withdraws, the last value it presented stays frozen.
        if (arb.req[r_owner]) w_number_next = w_num[r_owner];
        if (w_hold_done && !w_urg_vec[r_owner]) begin
          if (w_urg_any)       w_go_urgent = 1'b1;
          else if (w_pick_any) w_go_rotate = 1'b1;
          else                 w_go_idle   = 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_go_urgent) begin
      w_state_next  = S_URGENT;
      w_owner_next  = w_urg_idx;
      w_gnt_next    = {{(NREQ-1){1'b0}}, 1'b1} << w_urg_idx;
      w_number_next = w_num[w_urg_idx];
      w_blank_next  = 1'b0;
      w_hold_next   = '0;
      w_blink_next  = '0;
    end else if (w_go_rotate) begin
      w_state_next  = S_ROTATE;
      w_owner_next  = w_pick_idx;
      w_gnt_next    = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
      w_number_next = w_num[w_pick_idx];
      w_blank_next  = 1'b0;
      w_dwell_next  = '0;
    end else if (w_go_idle) begin
      w_state_next  = S_IDLE;
      w_gnt_next    = '0;
      w_blank_next  = 1'b1;
      w_dwell_next  = '0;
      w_hold_next   = '0;
      w_blink_next  = '0;
    end
  end

  always_ff @(posedge ms_clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_last   <= IW'(NREQ - 1);
      r_gnt       <= '0;
      r_number    <= 16'h0000;
      r_blank     <= 1'b1;
      r_dwell_cnt <= '0;
      r_hold_cnt  <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_rr_last   <= w_rr_last_next;
      r_gnt       <= w_gnt_next;
      r_number    <= w_number_next;
      r_blank     <= w_blank_next;
      r_dwell_cnt <= w_dwell_next;
      r_hold_cnt  <= w_hold_next;
      r_blink_cnt <= w_blink_next;
    end
  end

  assign arb.gnt    = r_gnt;
  assign arb.number = r_number;
  assign arb.blank  = r_blank;
endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter: rotation, lone re-grant, async reset, urgent
// preemption with blinking, urgent-to-urgent handover and return to IDLE.
module tb_disp_arbiter;
  localparam int NREQ = 4;

  logic ms_clock = 1'b0;
  logic reset    = 1'b0;
  int   chk_cnt  = 0;
  int   err_cnt  = 0;

  disp_arbiter_if #(.NREQ(NREQ)) arb ();

  disp_arbiter #(
    .NREQ(NREQ), .DWELL_MS(4), .MIN_HOLD_MS(3), .BLINK_MS(2)
  ) dut (
    .ms_clock(ms_clock),
    .reset   (reset),
    .arb     (arb)
  );

  always #5 ms_clock = ~ms_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle on the falling edge and log the transaction.
  task automatic tick();
    @(posedge ms_clock);
    @(negedge ms_clock);
    $display("t=%0t req=%b urg=%b gnt=%b number=%h blank=%b",
             $time, arb.req, arb.urgent, arb.gnt, arb.number, arb.blank);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [15:0] n, input logic b);
    check({tag, ".gnt"},    32'(arb.gnt),    32'(g));
    check({tag, ".number"}, 32'(arb.number), 32'(n));
    check({tag, ".blank"},  32'(arb.blank),  32'(b));
  endtask

  logic [3:0] rot_gnt [12];
  logic       blink_pat [5];

  initial begin
    rot_gnt   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
                  4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    blink_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    arb.req     = '0;
    arb.urgent  = '0;
    arb.req_num = {16'h9999, 16'h0042, 16'h0011, 16'h1234};

    #1 reset = 1'b1;
    #1 expect_out("por", 4'b0000, 16'h0000, 1'b1);
    @(negedge ms_clock);
    reset = 1'b0;

    // Two requesters rotate with a 4-cycle dwell each.
    arb.req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_out($sformatf("rot%0d", i), rot_gnt[i],
                 (rot_gnt[i] == 4'b0001) ? 16'h1234 : 16'h0042, 1'b0);
    end

    // Lone requester stays granted across dwell boundaries.
    arb.req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out($sformatf("lone%0d", i), 4'b0010, 16'h0011, 1'b0);
    end

    // Asynchronous reset while rotating.
    #2 reset = 1'b1;
    #1 expect_out("arst", 4'b0000, 16'h0000, 1'b1);
    @(negedge ms_clock);
    reset = 1'b0;

    // Owner 0 is preempted by urgent source 3 on the second dwell cycle.
    arb.req = 4'b0011;
    tick();
    expect_out("pre0", 4'b0001, 16'h1234, 1'b0);
    tick();
    expect_out("pre1", 4'b0001, 16'h1234, 1'b0);
    arb.req    = 4'b1011;
    arb.urgent = 4'b1000;
    tick();
    expect_out("urg3_0", 4'b1000, 16'h9999, 1'b0);
    tick();
    expect_out("urg3_1", 4'b1000, 16'h9999, 1'b0);
    arb.req    = 4'b0011;
    arb.urgent = 4'b0000;
    tick();
    expect_out("urg3_2", 4'b1000, 16'h9999, 1'b1);
    tick();
    expect_out("resume", 4'b0010, 16'h0011, 1'b0);

    // Urgents 1 and 2 together: 1 first with its blink pattern, then 2 directly.
    arb.req    = 4'b0111;
    arb.urgent = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("urg1_%0d", i), 4'b0010, 16'h0011, blink_pat[i]);
    end
    arb.req    = 4'b0101;
    arb.urgent = 4'b0100;
    tick();
    expect_out("urg2_0", 4'b0100, 16'h0042, 1'b0);
    arb.urgent = 4'b0000;
    tick();
    expect_out("urg2_1", 4'b0100, 16'h0042, 1'b0);
    tick();
    expect_out("urg2_2", 4'b0100, 16'h0042, 1'b1);
    tick();
    expect_out("rot_after", 4'b0100, 16'h0042, 1'b0);

    // All requests drop: IDLE with the last value held.
    arb.req = 4'b0000;
    tick();
    expect_out("idle0", 4'b0000, 16'h0042, 1'b1);
    tick();
    expect_out("idle1", 4'b0000, 16'h0042, 1'b1);

    // Urgent straight from IDLE, released at once: hold then back to IDLE.
    arb.req    = 4'b1000;
    arb.urgent = 4'b1000;
    tick();
    expect_out("iurg0", 4'b1000, 16'h9999, 1'b0);
    arb.req    = 4'b0000;
    arb.urgent = 4'b0000;
    tick();
    expect_out("iurg1", 4'b1000, 16'h9999, 1'b0);
    tick();
    expect_out("iurg2", 4'b1000, 16'h9999, 1'b1);
    tick();
    expect_out("iurg_idle", 4'b0000, 16'h9999, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
